cim_weight_loader: RTL and testbench
====================================

# cim_weight_loader

Weight-loading front end for the CIM macro. Accepts a valid/ready stream of 24-bit weight words, writes them into the shadow bank of the ping-pong array at consecutive row addresses, and owns the `cima` bank-select shared by `cim_array_ctrl` and `digital_circuit`. Once the shadow bank is fully loaded, a swap request from the compute sequencer makes it the compute bank. It drives the `WA`/`D` write side that the array and its controller consume.

## Interface
- `ADDR_W`, 8, row address width; bank depth is 2^ADDR_W.
- `DATA_W`, 24, weight word width; matches array `D`.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous active-low reset.
- `load_req`  in  1  one-cycle pulse; starts a bank load.
- `load_len`  in  ADDR_W+1  number of words, 1..2^ADDR_W; sampled with `load_req`.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  stream word accepted when `s_valid && s_ready`.
- `s_data`  in  DATA_W  weight word.
- `we`  out  1  registered write strobe to the array.
- `WA`  out  ADDR_W  write row address; valid when `we`=1.
- `D`  out  DATA_W  write data; valid when `we`=1.
- `cima`  out  1  bank select. Compute reads bank `cima`; writes go to bank `~cima`.
- `swap`  in  1  one-cycle pulse from the compute sequencer requesting a bank swap.
- `ready_bank`  out  1  shadow bank fully loaded and swappable.
- `busy`  out  1  a load is in progress.
- `load_err`  out  1  one-cycle pulse: `load_req` arrived outside IDLE.
- `swap_err`  out  1  one-cycle pulse: `swap` arrived while `ready_bank`=0.
- `chksum`  out  DATA_W  XOR of all words in the last or current load.

## Operation
- FSM states: IDLE, LOAD, FULL.
- **IDLE**
  - `load_req` with `load_len`≠0: go to LOAD, clear the address counter to 0, set the remaining count to `load_len`, clear `chksum`.
  - `load_req` with `load_len`=0 is ignored. No error pulse.
- **LOAD**
  - `s_ready`=1.
  - Each accepted word is registered into `D`, with `WA` = address counter and `we`=1 on the next cycle.
  - After each accepted word, the address increments and the remaining count decrements.
  - When the word that brings the remaining count to 0 is accepted, go to FULL.
  - The address never wraps, because `load_len` ≤ 2^ADDR_W.
  - `load_len` > 2^ADDR_W is clamped to 2^ADDR_W.
- **FULL**
  - `s_ready`=0.
  - `ready_bank` = (state==FULL) && !`we`.
  - `swap` while `ready_bank`=1: `cima` toggles at that edge, `ready_bank` drops, go to IDLE.
- `swap` in any other condition (IDLE, LOAD, or FULL while the final `we` is still high) is ignored, `swap_err` pulses the next cycle, and `cima` is unchanged.
- `load_req` in LOAD or FULL is ignored and `load_err` pulses the next cycle. This also applies in FULL when `swap` arrives in the same cycle: the swap is taken and the load is rejected.
- When `we`=0, `WA`/`D` hold their last values.
- `busy` = (state==LOAD).
- Reset mid-load abandons the load. Partial shadow-bank contents are don't-care. Outputs return to reset values.

## Timing
- Reset values: `we`=0, `WA`=0, `D`=0, `cima`=0, `s_ready`=0, `ready_bank`=0, `busy`=0, `load_err`=0, `swap_err`=0, `chksum`=0. FSM resets to IDLE.
- `load_req` at edge N → `s_ready`=1 from cycle N+1.
- Accept at edge k → `we`/`WA`/`D` valid in cycle k+1.
- Maximum throughput is one word per cycle.
- Last accept at edge k → last `we` in cycle k+1 → `ready_bank`=1 from cycle k+2.
- `swap` sampled at edge j with `ready_bank`=1 → new `cima` and `ready_bank`=0 in cycle j+1. A new `load_req` is accepted from edge j+1.
- All outputs are registered. There is no combinational path from inputs to outputs, except `s_ready`, which is a decode of state only.

## Configuration
- `CIM_LOADER_CHKSUM_EN`
  - Defined: `chksum` is XOR-accumulated with every accepted `s_data`, cleared on a taken `load_req`, and held through FULL and IDLE.
  - Undefined: no accumulator is synthesised and `chksum` is tied to 0.

## Test plan
- Reset → all outputs 0; after `rstn` releases, IDLE holds with no `we`.
- `load_req`, `load_len`=4; stream 0x000001..0x000004 back-to-back → four `we` cycles with `WA`=0,1,2,3 and matching `D`; `ready_bank`=1 one cycle after the last `we`; `chksum`=0x000004 (with the macro) or 0 (without it).
- `load_len`=3, `s_valid` toggling 1,0,1,0,1 → `we` only on accepts; `WA`=0,1,2 with no gaps or duplicates; `busy` high throughout.
- After the FULL state, `swap` pulse → `cima` 0→1 and `ready_bank` 0 the next cycle. A second `swap` in IDLE → `swap_err` pulse, `cima` stays 1.
- `load_len`=0 → no state change and no `load_err`. `load_len`=256 → 256 writes, last `WA`=0xFF. `load_req` during LOAD → `load_err` pulse, load unaffected.
- Assert `rstn` low after 2 of 5 words → `we`=0, `cima`=0, `ready_bank`=0. Then a new `load_req`, `load_len`=2 → writes at `WA`=0,1.

Source files
------------

// File: rtl/cim_weight_loader.sv
// ---------------------------------------------------------------------------
// cim_weight_loader
//
// Weight-loading front end for the CIM macro. Weight words arrive on a
// valid/ready stream and are written into the shadow bank of the ping-pong
// array at consecutive row addresses. This block owns the bank select `cima`:
// compute reads bank `cima`, writes go to bank `~cima`. After the shadow bank
// is fully loaded, a `swap` pulse from the compute sequencer flips `cima` so
// that the freshly loaded bank becomes the compute bank.
//
// Parameters:
//   ADDR_W     row address width; bank depth is 2**ADDR_W
//   DATA_W     weight word width (matches array D)
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   load_req   one-cycle pulse, starts a bank load
//   load_len   word count 1..2**ADDR_W, sampled with load_req (larger values
//              are clamped to 2**ADDR_W, zero is ignored)
//   s_valid    stream word valid
//   s_ready    stream ready (decode of FSM state only)
//   s_data     stream word
//   we         registered write strobe to the array
//   WA         write row address, valid while we=1
//   D          write data, valid while we=1
//   cima       bank select
//   swap       one-cycle bank swap request
//   ready_bank shadow bank fully loaded and swappable
//   busy       load in progress
//   load_err   one-cycle pulse: load_req arrived outside IDLE
//   swap_err   one-cycle pulse: swap arrived while ready_bank=0
//   chksum     XOR of all words in the last or current load
//
// Build option:
//   CIM_LOADER_CHKSUM_EN  when defined, chksum accumulates the XOR of every
//                         accepted word; when undefined, chksum is tied to 0
//                         and no accumulator exists.
// ---------------------------------------------------------------------------
module cim_weight_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              we,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] D,
  output logic              cima,
  input  logic              swap,
  output logic              ready_bank,
  output logic              busy,
  output logic              load_err,
  output logic              swap_err,
  output logic [DATA_W-1:0] chksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Full bank depth expressed in the load_len width.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remain;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wa;
  logic [DATA_W-1:0]   r_d;
  logic                r_cima;
  logic                r_load_err;
  logic                r_swap_err;

  logic [ADDR_W:0]     w_len_clamped;
  logic                w_load_take;
  logic                w_accept;
  logic                w_last;
  logic                w_swap_take;
  logic                w_s_ready;
  logic                w_busy;
  logic                w_ready_bank;

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  assign w_len_clamped = (load_len > DEPTH) ? DEPTH : load_len;
  assign w_load_take   = (r_state == ST_IDLE) && load_req && (load_len != '0);
  assign w_accept      = (r_state == ST_LOAD) && s_valid;
  assign w_last        = w_accept && (r_remain == ONE);
  // The bank is only swappable once the final write strobe has retired.
  assign w_swap_take   = swap && w_ready_bank;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_take) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_last) begin
          w_next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_swap_take) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode (registered state and write strobe only)
  // -------------------------------------------------------------------------
  always_comb begin
    w_s_ready    = 1'b0;
    w_busy       = 1'b0;
    w_ready_bank = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b0;
      end
      ST_LOAD: begin
        w_s_ready = 1'b1;
        w_busy    = 1'b1;
      end
      ST_FULL: begin
        w_ready_bank = !r_we;
      end
      default: begin
        w_s_ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Address / remaining-count counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_load_take) begin
      r_addr   <= '0;
      r_remain <= w_len_clamped;
    end else if (w_accept) begin
      r_remain <= r_remain - ONE;
      // Holding the address on the final word keeps it from wrapping on a
      // full-depth load.
      if (!w_last) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Array write port: one registered write per accepted word; WA/D hold
  // their last values while we=0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_d  <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_wa <= r_addr;
        r_d  <= s_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bank select and error pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cima     <= 1'b0;
      r_load_err <= 1'b0;
      r_swap_err <= 1'b0;
    end else begin
      if (w_swap_take) begin
        r_cima <= ~r_cima;
      end
      // A load request in FULL is rejected even when a swap is taken on the
      // same edge; a new load is only accepted from the following edge.
      r_load_err <= load_req && (r_state != ST_IDLE);
      r_swap_err <= swap && !w_ready_bank;
    end
  end

  // -------------------------------------------------------------------------
  // Load checksum
  // -------------------------------------------------------------------------
`ifdef CIM_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] r_chksum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_chksum <= '0;
    end else if (w_load_take) begin
      r_chksum <= '0;
    end else if (w_accept) begin
      r_chksum <= r_chksum ^ s_data;
    end
  end

  assign chksum = r_chksum;
`else
  assign chksum = '0;
`endif

  // -------------------------------------------------------------------------
  // Output ports
  // -------------------------------------------------------------------------
  assign s_ready    = w_s_ready;
  assign busy       = w_busy;
  assign ready_bank = w_ready_bank;
  assign we         = r_we;
  assign WA         = r_wa;
  assign D          = r_d;
  assign cima       = r_cima;
  assign load_err   = r_load_err;
  assign swap_err   = r_swap_err;

endmodule

// File: tb/tb_cim_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_cim_weight_loader
//
// Randomized self-checking bench for cim_weight_loader. A behavioural model
// tracks the load/full/idle phases, the words written per load and the bank
// select. Each accepted word pushes its expected {row, data} onto a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT raises its write strobe. Per-cycle control outputs are compared against
// the model after every clock.
// ---------------------------------------------------------------------------
module tb_cim_weight_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rstn;
  logic              load_req;
  logic [ADDR_W:0]   load_len;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              we;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] D;
  logic              cima;
  logic              swap;
  logic              ready_bank;
  logic              busy;
  logic              load_err;
  logic              swap_err;
  logic [DATA_W-1:0] chksum;

  cim_weight_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_req   (load_req),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .we         (we),
    .WA         (WA),
    .D          (D),
    .cima       (cima),
    .swap       (swap),
    .ready_bank (ready_bank),
    .busy       (busy),
    .load_err   (load_err),
    .swap_err   (swap_err),
    .chksum     (chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_FULL} mphase_t;
  mphase_t           m_ph      = M_IDLE;
  int                m_left    = 0;
  int                m_idx     = 0;
  bit                m_cima    = 1'b0;
  bit                m_wprev   = 1'b0;   // a word was accepted on the previous edge
  logic [DATA_W-1:0] m_chk     = '0;
  logic [31:0]       exp_q[$];           // {row, data}
  logic [ADDR_W-1:0] last_wa   = '0;

  function automatic logic [DATA_W-1:0] exp_chksum();
`ifdef CIM_LOADER_CHKSUM_EN
    return m_chk;
`else
    return '0;
`endif
  endfunction

  // ---------------- write monitor ----------------
  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we actual WA=0x%0h D=0x%0h expected no write t=%0t", WA, D, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("WA", 32'(WA), 32'(e[31:24]));
        chk("D", 32'(D), 32'(e[23:0]));
        last_wa = WA;
      end
    end
  end

  // One clock of stimulus, model update and control-output comparison.
  task automatic step(input bit lr, input logic [ADDR_W:0] ll, input bit sv,
                      input logic [DATA_W-1:0] d, input bit sw);
    bit acc, rb, e_lerr, e_serr;
    @(negedge clk);
    load_req = lr;
    load_len = ll;
    s_valid  = sv;
    s_data   = d;
    swap     = sw;
    @(posedge clk);
    acc    = sv && (m_ph == M_LOAD);
    rb     = (m_ph == M_FULL) && !m_wprev;
    e_lerr = lr && (m_ph != M_IDLE);
    e_serr = sw && !rb;
    case (m_ph)
      M_IDLE: if (lr && ll != 0) begin
        m_ph   = M_LOAD;
        m_left = (int'(ll) > DEPTH) ? DEPTH : int'(ll);
        m_idx  = 0;
        m_chk  = '0;
      end
      M_LOAD: if (acc) begin
        exp_q.push_back({8'(m_idx), d});
        m_idx++;
        m_left--;
        m_chk = m_chk ^ d;
        if (m_left == 0) m_ph = M_FULL;
      end
      default: if (sw && rb) begin
        m_cima = ~m_cima;
        m_ph   = M_IDLE;
      end
    endcase
    m_wprev = acc;
    #1;
    chk("load_err", 32'(load_err), 32'(e_lerr));
    chk("swap_err", 32'(swap_err), 32'(e_serr));
    chk("cima", 32'(cima), 32'(m_cima));
    chk("s_ready", 32'(s_ready), 32'(m_ph == M_LOAD));
    chk("busy", 32'(busy), 32'(m_ph == M_LOAD));
    chk("ready_bank", 32'(ready_bank), 32'((m_ph == M_FULL) && !acc));
    chk("chksum", 32'(chksum), 32'(exp_chksum()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // Streams words until the model reports the load complete.
  // mode 0: back-to-back, 1: alternating valid, 2: random valid.
  // req_at >= 0 injects a load_req on that cycle of the stream.
  task automatic send(input int mode, input int req_at);
    int cyc;
    bit v;
    cyc = 0;
    while (m_ph == M_LOAD && cyc < 3000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      step(cyc == req_at, 9'd5, v, DATA_W'($urandom), 1'b0);
      cyc++;
    end
    if (m_ph == M_LOAD) begin
      checks++;
      failures++;
      $display("FAIL load_timeout actual=still loading expected=load complete t=%0t", $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(we), 32'd0);
    chk({tag, "_WA"}, 32'(WA), 32'd0);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_cima"}, 32'(cima), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_ready_bank"}, 32'(ready_bank), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_swap_err"}, 32'(swap_err), 32'd0);
    chk({tag, "_chksum"}, 32'(chksum), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    load_req = 1'b0;
    s_valid  = 1'b0;
    swap     = 1'b0;
    #2;
    check_reset_outputs("midreset");
    chk("sb_empty_at_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_ph    = M_IDLE;
    m_cima  = 1'b0;
    m_wprev = 1'b0;
    m_chk   = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    load_req = 1'b0;
    load_len = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    swap     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    idle(4);

    // Four words 1..4 back-to-back; ready_bank follows the last write.
    step(1'b1, 9'd4, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, '0, 1'b1, DATA_W'(i), 1'b0);
    idle(1);
    chk("last_wa_len4", 32'(last_wa), 32'd3);
`ifdef CIM_LOADER_CHKSUM_EN
    chk("chksum_len4", 32'(chksum), 32'h4);
`else
    chk("chksum_len4", 32'(chksum), 32'h0);
`endif

    // Swap, then a swap in IDLE is rejected.
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("cima_after_swap", 32'(cima), 32'd1);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("cima_idle_swap", 32'(cima), 32'd1);

    // Alternating valid, three words.
    step(1'b1, 9'd3, 1'b0, '0, 1'b0);
    send(1, -1);
    idle(2);
    step(1'b0, '0, 1'b0, '0, 1'b1);

    // Zero length is ignored silently.
    step(1'b1, 9'd0, 1'b0, '0, 1'b0);
    idle(2);

    // Full-depth load with a rejected load_req mid-stream.
    step(1'b1, 9'd256, 1'b0, '0, 1'b0);
    send(0, 10);
    chk("last_wa_len256", 32'(last_wa), 32'hFF);
    // Swap while the final write is still in flight is rejected.
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    // Swap taken together with a rejected load_req.
    step(1'b1, 9'd7, 1'b0, '0, 1'b1);
    idle(1);

    // Oversized length clamps to full depth.
    step(1'b1, 9'd300, 1'b0, '0, 1'b0);
    send(2, -1);
    chk("last_wa_clamp", 32'(last_wa), 32'hFF);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);

    // Random loads, gaps and swaps.
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 9'($urandom_range(1, 40)), 1'b0, '0, 1'b0);
      send(int'($urandom_range(0, 2)), int'($urandom_range(0, 30)) - 10);
      idle(int'($urandom_range(0, 3)));
      step(1'($urandom_range(0, 1)), 9'd3, 1'b0, '0, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a five-word load.
    if (!m_cima) begin
      step(1'b1, 9'd1, 1'b0, '0, 1'b0);
      send(0, -1);
      idle(1);
      step(1'b0, '0, 1'b0, '0, 1'b1);
    end
    step(1'b1, 9'd5, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, DATA_W'($urandom), 1'b0);
    step(1'b0, '0, 1'b1, DATA_W'($urandom), 1'b0);
    do_reset();
    idle(2);
    step(1'b1, 9'd2, 1'b0, '0, 1'b0);
    send(0, -1);
    idle(2);
    chk("last_wa_after_reset", 32'(last_wa), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
